// File: rtl/lab2_timer_pkg.sv
// Register map, control-word bits and FSM state type for the system timer
// controller.
package lab2_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Interrupt enable + continuous reload + start, and the plain stop word.
  localparam logic [15:0] CTRL_GO   = 16'((32'd1 << CTRL_ITO) | (32'd1 << CTRL_CONT) |
                                          (32'd1 << CTRL_START));
  localparam logic [15:0] CTRL_HALT = 16'(32'd1 << CTRL_STOP);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_PL     = 4'd1,
    ST_WR_PH     = 4'd2,
    ST_WR_CTRL   = 4'd3,
    ST_RUN       = 4'd4,
    ST_ACK       = 4'd5,
    ST_SNAP_WR   = 4'd6,
    ST_SNAP_RL   = 4'd7,
    ST_SNAP_RH   = 4'd8,
    ST_SNAP_CAP  = 4'd9,
    ST_STOP_CTRL = 4'd10,
    ST_STOP_CLR  = 4'd11
  } tmr_state_e;

endpackage

// File: rtl/lab2_sys_timer_ctrl.sv
// Sequencer for an interval-timer slave: programs the period, services the
// timeout interrupt, takes counter snapshots and stops the timer.
//
// state        | meaning
// -------------+------------------------------------------------
// IDLE         | bus idle, waiting for cfg_start
// WR_PL        | write period[15:0] to PERIODL
// WR_PH        | write period[31:16] to PERIODH
// WR_CTRL      | write ITO|CONT|START to CONTROL
// RUN          | timer running, arbitrate stop / irq / snapshot
// ACK          | write STATUS to clear timeout, pulse tick
// SNAP_WR      | write SNAPL to latch the counter
// SNAP_RL      | read SNAPL
// SNAP_RH      | read SNAPH, capture low half
// SNAP_CAP     | capture high half, publish snapshot
// STOP_CTRL    | write STOP to CONTROL
// STOP_CLR     | write STATUS to clear any timeout
module lab2_sys_timer_ctrl
  import lab2_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [31:0] cfg_period,
  input  logic        cfg_stop,
  input  logic        snap_req,
  output logic [2:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic [15:0] tm_readdata,
  input  logic        tm_irq,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  tmr_state_e  state_q, state_d;
  logic [15:0] period_hi_q;
  logic [15:0] snap_lo_q;
  logic [31:0] tick_cnt_q;
  logic        pend_stop_q;
  logic        irq_mask_q;

  logic        bus_cs, bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  assign tick_count = tick_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cfg_start) state_d = ST_WR_PL;
      ST_WR_PL:     state_d = ST_WR_PH;
      ST_WR_PH:     state_d = ST_WR_CTRL;
      ST_WR_CTRL:   state_d = ST_RUN;
      ST_RUN: begin
        // The timer drops irq one cycle after the STATUS write, so the
        // first RUN cycle after ACK must not see it again.
        if (pend_stop_q)                 state_d = ST_STOP_CTRL;
        else if (tm_irq && !irq_mask_q)  state_d = ST_ACK;
        else if (snap_req)               state_d = ST_SNAP_WR;
      end
      ST_ACK:       state_d = ST_RUN;
      ST_SNAP_WR:   state_d = ST_SNAP_RL;
      ST_SNAP_RL:   state_d = ST_SNAP_RH;
      ST_SNAP_RH:   state_d = ST_SNAP_CAP;
      ST_SNAP_CAP:  state_d = ST_RUN;
      ST_STOP_CTRL: state_d = ST_STOP_CLR;
      ST_STOP_CLR:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Bus values for the cycle spent in state_d, so outputs line up with state.
  always_comb begin
    bus_cs   = 1'b0;
    bus_wn   = 1'b1;
    bus_addr = 3'd0;
    bus_data = 16'h0000;
    case (state_d)
      ST_WR_PL:     begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_PERIODL; bus_data = cfg_period[15:0]; end
      ST_WR_PH:     begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_PERIODH; bus_data = period_hi_q; end
      ST_WR_CTRL:   begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_CONTROL; bus_data = CTRL_GO; end
      ST_ACK:       begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_STATUS; end
      ST_SNAP_WR:   begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_SNAPL; end
      ST_SNAP_RL:   begin bus_cs = 1'b1; bus_addr = REG_SNAPL; end
      ST_SNAP_RH:   begin bus_cs = 1'b1; bus_addr = REG_SNAPH; end
      ST_STOP_CTRL: begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_CONTROL; bus_data = CTRL_HALT; end
      ST_STOP_CLR:  begin bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = REG_STATUS; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= 3'd0;
      tm_writedata  <= 16'h0000;
      busy          <= 1'b0;
      running       <= 1'b0;
      tick          <= 1'b0;
      tick_cnt_q    <= 32'd0;
      snap_value    <= 32'd0;
      snap_valid    <= 1'b0;
      snap_lo_q     <= 16'h0000;
      period_hi_q   <= 16'h0000;
      pend_stop_q   <= 1'b0;
      irq_mask_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tm_chipselect <= bus_cs;
      tm_write_n    <= bus_wn;
      tm_address    <= bus_addr;
      tm_writedata  <= bus_data;
      busy          <= (state_d != ST_IDLE);
      running       <= state_d inside {ST_RUN, ST_ACK, ST_SNAP_WR, ST_SNAP_RL,
                                       ST_SNAP_RH, ST_SNAP_CAP};
      tick          <= (state_d == ST_ACK);
      irq_mask_q    <= (state_q == ST_ACK);
      snap_valid    <= (state_q == ST_SNAP_CAP);

      if (state_q == ST_IDLE && cfg_start) begin
        period_hi_q <= cfg_period[31:16];
        tick_cnt_q  <= 32'd0;
      end else if (state_d == ST_ACK) begin
        tick_cnt_q  <= tick_cnt_q + 32'd1;
      end

      if (state_q == ST_SNAP_RH)  snap_lo_q  <= tm_readdata;
      if (state_q == ST_SNAP_CAP) snap_value <= {tm_readdata, snap_lo_q};

      if (state_d == ST_IDLE)
        pend_stop_q <= 1'b0;
      else if (cfg_stop && state_q != ST_IDLE)
        pend_stop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lab2_sys_timer_ctrl.sv
// Bench for lab2_sys_timer_ctrl: behavioural interval-timer slave, directed
// scenarios and a randomized run with snapshot/tick scoreboarding.
`timescale 1ns/1ps
module tb_lab2_sys_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_stop = 1'b0;
  logic        snap_req = 1'b0;
  logic [2:0]  tm_address;
  logic        tm_chipselect;
  logic        tm_write_n;
  logic [15:0] tm_writedata;
  logic [15:0] tm_readdata = 16'h0000;
  logic        tm_irq;
  logic        busy, running, tick, snap_valid;
  logic [31:0] tick_count, snap_value;

  lab2_sys_timer_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
    .cfg_stop(cfg_stop), .snap_req(snap_req), .tm_address(tm_address),
    .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n),
    .tm_writedata(tm_writedata), .tm_readdata(tm_readdata), .tm_irq(tm_irq),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural timer slave: down-counter with reload, timeout flag cleared
  // one cycle after a STATUS write, snapshot latched by a SNAPL write.
  localparam logic [31:0] FROZEN = 32'h0001_2345;
  logic [31:0] m_period = 0, m_count = 0, m_snap = 0;
  logic        m_run = 0, m_to = 0, m_ito = 0, m_clr_pend = 0;
  bit          m_frozen = 0;
  int          m_timeouts = 0;
  logic [31:0] exp_snaps[$];

  assign tm_irq = m_to & m_ito;

  always @(posedge clk) begin
    if (m_clr_pend) m_to <= 1'b0;
    m_clr_pend <= 1'b0;
    if (m_frozen) m_count <= FROZEN;
    else if (m_run) begin
      if (m_count == 0) begin
        m_to <= 1'b1;
        m_timeouts++;
        m_count <= m_period;
      end else m_count <= m_count - 1;
    end
    if (tm_chipselect && !tm_write_n) begin
      case (tm_address)
        3'd0: m_clr_pend <= 1'b1;
        3'd1: begin
          m_ito <= tm_writedata[0];
          if (tm_writedata[2]) begin m_run <= 1'b1; m_count <= m_period; end
          if (tm_writedata[3]) m_run <= 1'b0;
        end
        3'd2: m_period[15:0]  <= tm_writedata;
        3'd3: m_period[31:16] <= tm_writedata;
        3'd4: begin m_snap <= m_count; exp_snaps.push_back(m_count); end
        default: ;
      endcase
    end
    if (tm_chipselect && tm_write_n)
      tm_readdata <= (tm_address == 3'd4) ? m_snap[15:0] :
                     (tm_address == 3'd5) ? m_snap[31:16] : {14'd0, m_run, m_to};
  end

  // Bus log entries are {is_write, address, writedata}; reads log data 0.
  logic [19:0] bus_log[$];
  int tick_seen = 0, snapv_seen = 0;
  bit chk_snaps = 0;

  always @(negedge clk) begin
    if (tm_chipselect)
      bus_log.push_back({!tm_write_n, tm_address, tm_write_n ? 16'h0 : tm_writedata});
    else if (!reset)
      check("idle_write_n", tm_write_n, 1'b1);
    if (tick) tick_seen++;
    if (snap_valid) begin
      snapv_seen++;
      if (chk_snaps) begin
        if (exp_snaps.size() == 0) check("snap_unexpected", 1'b1, 1'b0);
        else check("rand_snap_value", snap_value, exp_snaps.pop_front());
      end
    end
  end

  function automatic int count_log(input logic [19:0] pat);
    int n = 0;
    foreach (bus_log[i]) if (bus_log[i] == pat) n++;
    return n;
  endfunction

  function automatic int count_reads();
    int n = 0;
    foreach (bus_log[i]) if (!bus_log[i][19]) n++;
    return n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_timer(input logic [31:0] p);
    cfg_period = p;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    check(tag, busy, 1'b0);
  endtask

  task automatic stop_timer(input string tag);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_idle(tag);
    @(negedge clk);
  endtask

  task automatic wait_tick(input string tag);
    int k = 0;
    while (!tick && k < 200) begin @(negedge clk); k++; end
    check(tag, tick, 1'b1);
  endtask

  initial begin
    int base, k;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;

    // Reset state
    cyc(3);
    check("rst_bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    check("rst_flags", {busy, running, tick, snap_valid}, 4'b0000);
    check("rst_tick_count", tick_count, 32'd0);
    check("rst_snap_value", snap_value, 32'd0);
    reset = 1'b0;
    cyc(2);

    // cfg_stop in IDLE is ignored, then the programming sequence
    cfg_stop = 1'b1; @(negedge clk); cfg_stop = 1'b0; @(negedge clk);
    check("stop_in_idle", busy, 1'b0);
    start_timer(32'h02FA_F07F);
    check("prog_pl", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd2, 16'hF07F});
    check("prog_busy", {busy, running}, 2'b10);
    @(negedge clk);
    check("prog_ph", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd3, 16'h02FA});
    @(negedge clk);
    check("prog_ctrl", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd1, 16'h0007});
    @(negedge clk);
    check("prog_running", {busy, running, tm_chipselect}, 3'b110);
    cyc(3);
    check("still_running", running, 1'b1);
    bus_log.delete();
    stop_timer("stop_idle");
    check("stop_seq_len", bus_log.size(), 2);
    check("stop_seq_ctrl", bus_log[0], {1'b1, 3'd1, 16'h0008});
    check("stop_seq_clr", bus_log[1], {1'b1, 3'd0, 16'h0000});

    // cfg_stop during WR_PH, period 0 written verbatim
    bus_log.delete();
    start_timer(32'd0);
    @(negedge clk);
    check("ph_state", tm_address, 3'd3);
    cfg_stop = 1'b1; @(negedge clk); cfg_stop = 1'b0;
    wait_idle("stop_ph_idle");
    @(negedge clk);
    check("stop_ph_len", bus_log.size(), 5);
    check("stop_ph_0", bus_log[0], {1'b1, 3'd2, 16'h0000});
    check("stop_ph_1", bus_log[1], {1'b1, 3'd3, 16'h0000});
    check("stop_ph_2", bus_log[2], {1'b1, 3'd1, 16'h0007});
    check("stop_ph_3", bus_log[3], {1'b1, 3'd1, 16'h0008});
    check("stop_ph_4", bus_log[4], {1'b1, 3'd0, 16'h0000});
    cyc(3);

    // Three timeouts with period 9
    bus_log.delete();
    tick_seen = 0;
    base = m_timeouts;
    start_timer(32'd9);
    k = 0;
    while (m_timeouts - base < 3 && k < 300) begin @(negedge clk); k++; end
    check("timeouts_reached", m_timeouts - base, 3);
    cyc(3);
    check("tick_pulses", tick_seen, 3);
    check("ack_writes", count_log({1'b1, 3'd0, 16'h0000}), 3);
    check("tick_count_3", tick_count, 32'd3);

    // Counter wrap on the next serviced timeout
    dut.tick_cnt_q = 32'hFFFF_FFFF;
    wait_tick("wrap_tick");
    check("tick_count_wrap", tick_count, 32'd0);
    stop_timer("stop_wrap");

    // Snapshot of a frozen counter
    m_frozen = 1;
    start_timer(32'h0010_0000);
    cyc(4);
    bus_log.delete();
    snapv_seen = 0;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    cyc(8);
    check("snap_len", bus_log.size(), 3);
    check("snap_wr", bus_log[0], {1'b1, 3'd4, 16'h0000});
    check("snap_rl", bus_log[1], {1'b0, 3'd4, 16'h0000});
    check("snap_rh", bus_log[2], {1'b0, 3'd5, 16'h0000});
    check("snap_value", snap_value, FROZEN);
    check("snap_valid_once", snapv_seen, 1);
    stop_timer("stop_snap");
    m_frozen = 0;
    cyc(2);

    // irq and snap_req in the same RUN cycle
    bus_log.delete();
    tick_seen = 0;
    snapv_seen = 0;
    start_timer(32'd9);
    k = 0;
    while (!tm_irq && k < 100) begin @(negedge clk); k++; end
    check("irq_seen", tm_irq, 1'b1);
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    cyc(5);
    check("race_ack_first", count_log({1'b1, 3'd0, 16'h0000}), 1);
    check("race_no_reads", count_reads(), 0);
    check("race_no_snap", snapv_seen, 0);
    check("race_tick", tick_seen, 1);
    stop_timer("stop_race");

    // Reset in WR_PH with a pending stop; pending stop must not survive
    bus_log.delete();
    start_timer(32'h1234_5678);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    check("rst_ph_state", tm_address, 3'd3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1 ^ 1'b1, 1'b1, 3'd0, 16'h0});
    check("rst_mid_flags", {busy, running, tick, snap_valid}, 4'b0000);
    check("rst_mid_tick_count", tick_count, 32'd0);
    check("rst_mid_snap", snap_value, 32'd0);
    reset = 1'b0;
    cyc(2);
    check("rst_mid_no_ctrl", count_log({1'b1, 3'd1, 16'h0007}), 0);
    start_timer(32'h0010_0000);
    cyc(8);
    check("rst_pend_cleared", {busy, running}, 2'b11);
    stop_timer("stop_after_rst");

    // Randomized runs: snapshots scoreboarded, ticks against model timeouts
    for (int it = 0; it < 4; it++) begin
      exp_snaps.delete();
      chk_snaps = 1;
      bus_log.delete();
      base = m_timeouts;
      start_timer($urandom_range(12, 40));
      for (int c = 0; c < 250; c++) begin
        snap_req   = ($urandom_range(0, 5) == 0);
        cfg_start  = ($urandom_range(0, 30) == 0);
        cfg_period = $urandom;
        @(negedge clk);
      end
      snap_req = 1'b0;
      cfg_start = 1'b0;
      wait_tick("rand_last_tick");
      stop_timer("rand_stop");
      check("rand_tick_count", tick_count, m_timeouts - base);
      check("rand_snaps_drained", exp_snaps.size(), 0);
      check("rand_start_ignored", count_log({1'b1, 3'd2, bus_log[0][15:0]}) + count_reads() * 0, 1);
      cyc(5);
      check("rand_hold", tick_count, m_timeouts - base);
      chk_snaps = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab2_sys_timer_ctrl.md
LAB2_SYS_TIMER_CTRL -- requirements
Module: lab2_sys_timer_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: cfg_start  input  1  one-cycle pulse; program cfg_period and start the timer.
REQ-004 SHALL: cfg_period  input  32  timer period; sampled only when cfg_start is accepted.
REQ-005 SHALL: cfg_stop  input  1  one-cycle pulse; stop the timer.
REQ-006 SHALL: snap_req  input  1  one-cycle pulse; request a counter snapshot.
REQ-007 SHALL: tm_address  output  3  timer slave word address.
REQ-008 SHALL: tm_chipselect  output  1  timer slave select.
REQ-009 SHALL: tm_write_n  output  1  timer write strobe, active-low.
REQ-010 SHALL: tm_writedata  output  16  timer write data.
REQ-011 SHALL: tm_readdata  input  16  timer read data; valid one cycle after the address is presented; no waitrequest.
REQ-012 SHALL: tm_irq  input  1  timer interrupt, level.
REQ-013 SHALL: busy  output  1  high in every state except IDLE.
REQ-014 SHALL: running  output  1  high in RUN, SNAP_* and ACK states.
REQ-015 SHALL: tick  output  1  one-cycle pulse per serviced timeout.
REQ-016 SHALL: tick_count  output  32  serviced timeouts since last start; wraps 0xFFFFFFFF -> 0.
REQ-017 SHALL: snap_value  output  32  last snapshot {high, low}.
REQ-018 SHALL: snap_valid  output  1  one-cycle pulse when snap_value updates.

Function
REQ-019 SHALL: all outputs are registered; idle bus is chipselect=0, write_n=1.
REQ-020 SHALL: states are IDLE, WR_PL, WR_PH, WR_CTRL, RUN, ACK, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, STOP_CTRL, STOP_CLR.
REQ-021 SHALL: each write state performs exactly one single-cycle bus write: chipselect=1, write_n=0.
REQ-022 SHALL: IDLE + cfg_start -> WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL (addr 1, data 0x0007 = ITO|CONT|START) -> RUN.
REQ-023 SHALL: tick_count is cleared when cfg_start is accepted.
REQ-024 SHALL: cfg_start is ignored outside IDLE.
REQ-025 SHALL: in RUN, priority is pending stop > tm_irq > snap_req.
REQ-026 SHALL: RUN + tm_irq -> ACK, which writes addr 0, data 0x0000, pulses tick in the same cycle, increments tick_count, then returns to RUN.
REQ-027 SHALL: tm_irq is ignored in the cycle immediately after ACK; the timer clears its irq one cycle late.
REQ-028 SHALL: RUN + snap_req follows this sequence, then returns to RUN:
  - SNAP_WR: write addr 4.
  - SNAP_RL: read addr 4 (chipselect=1, write_n=1).
  - SNAP_RH: read addr 5; capture tm_readdata as the low half.
  - SNAP_CAP: bus idle; capture tm_readdata as the high half; pulse snap_valid.
REQ-029 SHALL: snap_req arriving outside RUN, or losing to tm_irq, is dropped; tm_irq during SNAP_* is serviced on return to RUN (level held).
REQ-030 SHALL: cfg_stop in any busy state sets a pending-stop flag, acted on at the next RUN entry.
REQ-031 SHALL: cfg_stop in IDLE is ignored.
REQ-032 SHALL: stop sequence is STOP_CTRL (addr 1, data 0x0008 = STOP) -> STOP_CLR (addr 0, data 0x0000) -> IDLE; pending-stop is cleared.
REQ-033 SHALL: tick_count and snap_value hold their values across stop.
REQ-034 SHALL: cfg_period = 0 is written unmodified.

Reset
REQ-035 SHALL: asserting reset at any time forces IDLE, idle bus, tm_address=0, tm_writedata=0, busy=0, running=0, tick=0, tick_count=0, snap_value=0, snap_valid=0, pending-stop=0.
REQ-036 SHALL: reset mid-sequence aborts the sequence with no further bus writes; the timer keeps its own state.

Structure
REQ-037 SHALL: shared package lab2_timer_pkg holds:
  - register offsets STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5;
  - control bit constants ITO=0, CONT=1, START=2, STOP=3;
  - the state enum typedef.
REQ-038 SHALL: the block is a single module with no sub-modules.

Verification
REQ-039 SHALL: cfg_start with cfg_period=0x02FAF07F -> writes (2,0xF07F), (3,0x02FA), (1,0x0007) on three consecutive cycles; busy=1; running=1 on the 4th cycle.
REQ-040 SHALL: with period=9 on a behavioural timer model, 3 timeouts -> 3 ACK writes (0,0x0000), 3 tick pulses, tick_count=3, no double count per irq.
REQ-041 SHALL: snap_req with model counter frozen at 0x00012345 -> SNAP_WR, reads at 4 and 5, snap_value=0x00012345, snap_valid high exactly one cycle.
REQ-042 SHALL: cfg_stop during WR_PH -> WR_CTRL completes, then (1,0x0008), (0,0x0000), IDLE, busy=0.
REQ-043 SHALL: tm_irq and snap_req in the same RUN cycle -> ACK first, snapshot dropped, snap_valid stays 0.
REQ-044 SHALL: reset asserted in WR_PH -> next cycle chipselect=0, write_n=1, all outputs at reset values; tick_count=0xFFFFFFFF plus one tick -> 0.
